// File: rtl/jk_bank_arbiter_pkg.sv
// jk_bank_arbiter_pkg: shared JK command codes and arbiter FSM state encoding
package jk_bank_arbiter_pkg;
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;
endpackage

// File: rtl/jk_bank_arbiter_cell.sv
// jk_cell: single JK flip-flop bit with write enable
// Ports: clk, rst (async, active-high), enable (apply j/k this edge), j, k, q (stored bit)
module jk_cell
   import jk_bank_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic j,
   input  logic k,
   output logic q
);
   logic r_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_q <= 1'b0;
      else if (enable)
         r_q <= ({j, k} == JK_TGL) ? ~r_q :
                ({j, k} == JK_SET) ? 1'b1 :
                ({j, k} == JK_CLR) ? 1'b0 : r_q;
   end
   assign q = r_q;
endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter with optional timed lock, sole writer of a JK bit bank
// Ports: clk, rst (async, active-high); req_valid/req_ready per-requester handshake;
//        req_idx/req_jk/req_lock packed per-requester command fields; q bank contents;
//        grant_valid/grant_id same-cycle accept; locked FSM state; cmd_count accept counter
module jk_bank_arbiter
   import jk_bank_arbiter_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int NBITS    = 8,
   parameter int IDXW     = $clog2(NBITS),
   parameter int LOCK_MAX = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*IDXW-1:0]      req_idx,
   input  logic [NREQ*2-1:0]         req_jk,
   input  logic [NREQ-1:0]           req_lock,
   output logic [NBITS-1:0]          q,
   output logic                      grant_valid,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      locked,
   output logic [15:0]               cmd_count
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(LOCK_MAX + 1);
   state_t           r_state, w_state_nx;
   logic [IDW-1:0]   r_owner, w_owner_nx, r_rr_ptr, w_rr_nx, w_win, w_sel;
   logic [CW-1:0]    r_idle, w_idle_nx;
   logic [15:0]      r_cmd_count;
   logic             w_found, w_hit, w_accept, w_lock;
   logic [NREQ-1:0]  w_ready;
   logic [IDXW-1:0]  w_idx;
   logic [1:0]       w_jk;
   // Walk offsets from farthest to nearest so the requester closest to rr_ptr wins
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      for (int o = NREQ - 1; o >= 0; o--) begin
         if (req_valid[(int'(r_rr_ptr) + o) % NREQ]) begin
            w_found = 1'b1;
            w_win   = IDW'((int'(r_rr_ptr) + o) % NREQ);
         end
      end
   end
   always_comb begin
      w_ready = '0;
      w_sel   = (r_state == ST_LOCKED) ? r_owner : w_win;
      w_hit   = (r_state == ST_LOCKED) ? req_valid[r_owner] : w_found;
      if (!rst && w_hit) w_ready[w_sel] = 1'b1;
   end
   assign w_accept    = |w_ready;
   assign w_idx       = req_idx[w_sel*IDXW +: IDXW];
   assign w_jk        = req_jk[w_sel*2 +: 2];
   assign w_lock      = req_lock[w_sel];
   assign req_ready   = w_ready;
   assign grant_valid = w_accept;
   assign grant_id    = w_accept ? w_sel : '0;
   assign locked      = (r_state == ST_LOCKED);
   assign cmd_count   = r_cmd_count;
   // rr_ptr only moves on IDLE accepts, so after a lock releases it already points at owner+1
   always_comb begin
      w_state_nx = r_state;
      w_owner_nx = r_owner;
      w_rr_nx    = r_rr_ptr;
      w_idle_nx  = '0;
      if (r_state == ST_IDLE) begin
         if (w_accept) w_rr_nx = (w_sel == IDW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
         if (w_accept && w_lock) begin
            w_state_nx = ST_LOCKED;
            w_owner_nx = w_sel;
         end
      end else if (w_accept) w_state_nx = w_lock ? ST_LOCKED : ST_IDLE;
      else if (r_idle == CW'(LOCK_MAX - 1)) w_state_nx = ST_IDLE;
      else w_idle_nx = r_idle + 1'b1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_idle      <= '0;
         r_cmd_count <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_owner     <= w_owner_nx;
         r_rr_ptr    <= w_rr_nx;
         r_idle      <= w_idle_nx;
         r_cmd_count <= r_cmd_count + 16'(w_accept);
      end
   end
   for (genvar i = 0; i < NBITS; i++) begin : g_cell
      jk_cell u_cell (
         .clk    (clk),
         .rst    (rst),
         .enable (w_accept && (w_idx == IDXW'(i))),
         .j      (w_jk[1]),
         .k      (w_jk[0]),
         .q      (q[i])
      );
   end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: table vectors, directed corner sequences and random traffic against a reference model
module tb_jk_bank_arbiter;
   import jk_bank_arbiter_pkg::*;
   localparam int NREQ = 4, NBITS = 8, IDXW = 4, LOCK_MAX = 16;
   logic                   clk = 1'b0, rst = 1'b1;
   logic [NREQ-1:0]        req_valid = '0, req_ready, req_lock = '0;
   logic [NREQ*IDXW-1:0]   req_idx = '0;
   logic [NREQ*2-1:0]      req_jk = '0;
   logic [NBITS-1:0]       q;
   logic                   grant_valid, locked;
   logic [1:0]             grant_id;
   logic [15:0]            cmd_count;
   int nchk = 0, nerr = 0;
   int m_rr, m_owner, m_idle, m_cnt, obs_gid;
   bit m_locked, obs_locked;
   logic [NBITS-1:0] m_q;
   typedef struct { logic [1:0] jk; int idx; logic [7:0] q; } jk_row_t;
   jk_row_t jk_tbl[6];
   int rr_exp[5] = '{0, 1, 2, 3, 0};
   jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
      .req_jk(req_jk), .req_lock(req_lock), .q(q), .grant_valid(grant_valid),
      .grant_id(grant_id), .locked(locked), .cmd_count(cmd_count)
   );
   always #5 clk = ~clk;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask
   task automatic set_req(int r, bit v, int ix, logic [1:0] jk, bit lk);
      req_valid[r] = v;
      req_idx[r*IDXW +: IDXW] = IDXW'(ix);
      req_jk[r*2 +: 2] = jk;
      req_lock[r] = lk;
   endtask
   task automatic clear_reqs();
      req_valid = '0; req_lock = '0; req_idx = '0; req_jk = '0;
   endtask
   task automatic m_reset();
      m_rr = 0; m_owner = 0; m_idle = 0; m_cnt = 0; m_locked = 0; m_q = '0;
   endtask
   task automatic m_pick(output bit gv, output int gid);
      gv = 0; gid = 0;
      if (m_locked) begin
         gv = req_valid[m_owner];
         gid = gv ? m_owner : 0;
      end else
         for (int o = 0; o < NREQ; o++)
            if (!gv && req_valid[(m_rr + o) % NREQ]) begin gv = 1; gid = (m_rr + o) % NREQ; end
   endtask
   task automatic m_commit();
      bit gv; int gid, ix; logic [1:0] jk;
      m_pick(gv, gid);
      if (gv) begin
         ix = int'(req_idx[gid*IDXW +: IDXW]);
         jk = req_jk[gid*2 +: 2];
         if (ix < NBITS) m_q[ix] = (jk == JK_SET) ? 1'b1 : (jk == JK_CLR) ? 1'b0 : (jk == JK_TGL) ? ~m_q[ix] : m_q[ix];
         m_cnt = (m_cnt + 1) % 65536;
         if (!m_locked) begin
            m_rr = (gid + 1) % NREQ;
            if (req_lock[gid]) begin m_locked = 1; m_owner = gid; end
         end else if (!req_lock[gid]) m_locked = 0;
         m_idle = 0;
      end else if (m_locked) begin
         m_idle++;
         if (m_idle == LOCK_MAX) begin m_locked = 0; m_idle = 0; end
      end
   endtask
   // Starts just after a posedge with inputs set; checks mid-cycle, then advances one edge
   task automatic step();
      bit gv; int gid;
      @(negedge clk);
      m_pick(gv, gid);
      chk("ready", req_ready, gv ? (1 << gid) : 0);
      chk("gvalid", grant_valid, gv);
      chk("gid", grant_id, gid);
      chk("locked", locked, m_locked);
      chk("q", q, m_q);
      chk("cnt", cmd_count, m_cnt);
      obs_gid = grant_id;
      obs_locked = locked;
      @(posedge clk);
      m_commit();
      #1;
   endtask
   initial begin
      jk_tbl[0] = '{JK_SET,  3, 8'h08};
      jk_tbl[1] = '{JK_TGL,  3, 8'h00};
      jk_tbl[2] = '{JK_TGL,  3, 8'h08};
      jk_tbl[3] = '{JK_HOLD, 3, 8'h08};
      jk_tbl[4] = '{JK_CLR,  3, 8'h00};
      jk_tbl[5] = '{JK_SET,  9, 8'h00};
      m_reset();
      for (int r = 0; r < NREQ; r++) set_req(r, 1, 0, JK_SET, 1);
      #3;
      chk("rst_ready", req_ready, 0);
      chk("rst_gvalid", grant_valid, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_q", q, 0);
      chk("rst_locked", locked, 0);
      chk("rst_cnt", cmd_count, 0);
      @(negedge clk);
      clear_reqs();
      rst = 1'b0;
      @(posedge clk); #1;
      for (int r = 0; r < NREQ; r++) set_req(r, 1, 0, JK_HOLD, 0);
      for (int n = 0; n < 5; n++) begin
         step();
         chk("rr_gid", obs_gid, rr_exp[n]);
      end
      chk("rr_cnt", cmd_count, 5);
      clear_reqs();
      for (int n = 0; n < 6; n++) begin
         set_req(0, 1, jk_tbl[n].idx, jk_tbl[n].jk, 0);
         step();
         chk("jk_q", q, jk_tbl[n].q);
      end
      chk("oob_cnt", cmd_count, 11);
      clear_reqs();
      set_req(1, 1, 0, JK_HOLD, 0);
      step();
      for (int r = 0; r < NREQ; r++) set_req(r, 1, r, JK_HOLD, r == 2);
      for (int n = 0; n < 3; n++) begin
         step();
         chk("lock_gid", obs_gid, 2);
         chk("lock_held", locked, 1);
      end
      set_req(2, 1, 2, JK_HOLD, 0);
      step();
      chk("unlock_gid", obs_gid, 2);
      chk("unlock_fall", locked, 0);
      step();
      chk("after_unlock_gid", obs_gid, 3);
      clear_reqs();
      set_req(1, 1, 1, JK_HOLD, 1);
      step();
      chk("to_lock_gid", obs_gid, 1);
      clear_reqs();
      for (int n = 0; n < LOCK_MAX; n++) begin
         step();
         chk("to_still_locked", obs_locked, 1);
      end
      chk("to_released", locked, 0);
      set_req(1, 1, 1, JK_HOLD, 0);
      set_req(2, 1, 2, JK_HOLD, 0);
      step();
      chk("to_next_gid", obs_gid, 2);
      clear_reqs();
      set_req(0, 1, 5, JK_TGL, 0);
      set_req(2, 1, 5, JK_TGL, 0);
      step();
      chk("cont_first", obs_gid, 0);
      chk("cont_mid", q[5], 1);
      set_req(0, 0, 0, JK_HOLD, 0);
      step();
      chk("cont_second", obs_gid, 2);
      chk("cont_end", q[5], 0);
      clear_reqs();
      for (int n = 0; n < 600; n++) begin
         for (int r = 0; r < NREQ; r++)
            set_req(r, ((n / 40) % 3 == 2) ? ($urandom_range(19) == 0) : ($urandom_range(2) != 0),
                    $urandom_range(9), 2'($urandom_range(3)), $urandom_range(3) == 0);
         step();
      end
      clear_reqs();
      step();
      set_req(3, 1, 7, JK_SET, 1);
      step();
      chk("ml_locked", locked, 1);
      chk("ml_q7", q[7], 1);
      #1 rst = 1'b1;
      #1;
      chk("ml_ready", req_ready, 0);
      chk("ml_gvalid", grant_valid, 0);
      chk("ml_q", q, 0);
      chk("ml_lock_drop", locked, 0);
      chk("ml_cnt", cmd_count, 0);
      m_reset();
      clear_reqs();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int r = 0; r < NREQ; r++) set_req(r, 1, 1, JK_SET, 0);
      step();
      chk("post_rst_gid", obs_gid, 0);
      chk("post_rst_q", q, 8'h02);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
